// File: rtl/mem_stage_if.sv
// Data-memory request/response port of the LC-3b MEM stage.
// The stage is the master; the data memory (or cache) is the slave.
interface mem_stage_if;
  logic [15:0] dmem_address;
  logic        dmem_read;
  logic        dmem_write;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic [15:0] dmem_rdata;
  logic        dmem_resp;

  modport master (
    output dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_enable,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_address, dmem_read, dmem_write, dmem_wdata, dmem_byte_enable,
    output dmem_rdata, dmem_resp
  );
endinterface

// File: rtl/mem_stage.sv
// LC-3b pipeline memory stage: word/byte/indirect loads and stores over a
// request/response port, stalling upstream until the access completes.
package lc3b_types;
  typedef logic [15:0] lc3b_word;

  typedef enum logic [2:0] {
    OP_NONE = 3'b000,
    OP_LDW  = 3'b001,
    OP_LDB  = 3'b010,
    OP_STW  = 3'b011,
    OP_STB  = 3'b100,
    OP_LDI  = 3'b101,
    OP_STI  = 3'b110,
    OP_RSVD = 3'b111
  } mem_op_t;
endpackage

module mem_stage
  import lc3b_types::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  input  logic [2:0]         mem_op,
  input  lc3b_word           alu_out,
  input  lc3b_word           store_data,
  input  lc3b_word           branch_address,
  input  lc3b_word           pc_plus2,
  input  logic [2:0]         regfilemux_sel,
  mem_stage_if.master        dmem,
  output logic               stall_out,
  output logic               wb_valid,
  output lc3b_word           wb_alu_out,
  output lc3b_word           wb_branch_address,
  output lc3b_word           wb_pc_plus2,
  output lc3b_word           wb_mem_rdata,
  output logic [2:0]         wb_regfilemux_sel,
  output logic               wb_byte_sel
);

  typedef enum logic {S_FIRST, S_SECOND} state_t;

  state_t   state, state_next;
  lc3b_word ind_addr;
  mem_op_t  op;
  logic     is_mem, is_ind, is_load, done, ptr_load;
  lc3b_word word_addr;

  assign op        = mem_op_t'(mem_op);
  assign word_addr = {alu_out[15:1], 1'b0};

  always_comb begin
    is_mem   = in_valid && (op != OP_NONE) && (op != OP_RSVD);
    is_ind   = (op == OP_LDI) || (op == OP_STI);
    is_load  = (op == OP_LDW) || (op == OP_LDB) || (op == OP_LDI);
    // A response with no request outstanding (is_mem low) must not count.
    done     = is_mem && dmem.dmem_resp &&
               (((state == S_FIRST) && !is_ind) || (state == S_SECOND));
    ptr_load = is_mem && is_ind && (state == S_FIRST) && dmem.dmem_resp;
  end

  assign stall_out = !reset && is_mem && !done;

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next             = state;
    dmem.dmem_address      = word_addr;
    dmem.dmem_read         = 1'b0;
    dmem.dmem_write        = 1'b0;
    dmem.dmem_wdata        = '0;
    dmem.dmem_byte_enable  = 2'b00;

    if (!reset && is_mem) begin
      if (state == S_SECOND) begin
        dmem.dmem_address     = ind_addr;
        dmem.dmem_byte_enable = 2'b11;
        if (op == OP_STI) begin
          dmem.dmem_write = 1'b1;
          dmem.dmem_wdata = store_data;
        end else begin
          dmem.dmem_read  = 1'b1;
        end
        if (dmem.dmem_resp) state_next = S_FIRST;
      end else begin
        unique case (op)
          OP_LDW, OP_LDI, OP_STI: begin
            dmem.dmem_read        = 1'b1;
            dmem.dmem_byte_enable = 2'b11;
          end
          OP_LDB: begin
            dmem.dmem_address     = alu_out;
            dmem.dmem_read        = 1'b1;
            dmem.dmem_byte_enable = alu_out[0] ? 2'b10 : 2'b01;
          end
          OP_STW: begin
            dmem.dmem_write       = 1'b1;
            dmem.dmem_wdata       = store_data;
            dmem.dmem_byte_enable = 2'b11;
          end
          OP_STB: begin
            dmem.dmem_address     = alu_out;
            dmem.dmem_write       = 1'b1;
            dmem.dmem_wdata       = {store_data[7:0], store_data[7:0]};
            dmem.dmem_byte_enable = alu_out[0] ? 2'b10 : 2'b01;
          end
          default: ;
        endcase
        if (ptr_load) state_next = S_SECOND;
      end
    end else if (state == S_SECOND) begin
      // Instruction vanished mid-indirect; recover to a clean FIRST.
      state_next = S_FIRST;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FIRST;
      ind_addr <= '0;
    end else begin
      state <= state_next;
      if (ptr_load) ind_addr <= {dmem.dmem_rdata[15:1], 1'b0};
    end
  end

  // MEM/WB register: loads the instruction when not stalled, a bubble otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_valid          <= 1'b0;
      wb_alu_out        <= '0;
      wb_branch_address <= '0;
      wb_pc_plus2       <= '0;
      wb_mem_rdata      <= '0;
      wb_regfilemux_sel <= '0;
      wb_byte_sel       <= 1'b0;
    end else if (!stall_out) begin
      wb_valid          <= in_valid;
      wb_alu_out        <= alu_out;
      wb_branch_address <= branch_address;
      wb_pc_plus2       <= pc_plus2;
      wb_mem_rdata      <= (is_mem && is_load) ? dmem.dmem_rdata : '0;
      wb_regfilemux_sel <= regfilemux_sel;
      wb_byte_sel       <= (is_mem && (op == OP_LDB)) ? alu_out[0] : 1'b0;
    end else begin
      wb_valid          <= 1'b0;
      wb_alu_out        <= '0;
      wb_branch_address <= '0;
      wb_pc_plus2       <= '0;
      wb_mem_rdata      <= '0;
      wb_regfilemux_sel <= '0;
      wb_byte_sel       <= 1'b0;
    end
  end

endmodule
